// File: rtl/ibex_csr_access_pkg.sv
// Shared types for the shadowed CSR access sequencer and its arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: csr_op_e (access operation codes), csr_access_state_e
// (sequencer states), NumPorts (number of requesting ports).
package ibex_csr_access_pkg;

  localparam int NumPorts = 2;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    WRITE = 2'd1,
    SET   = 2'd2,
    CLEAR = 2'd3
  } csr_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } csr_access_state_e;

endpackage

// File: rtl/ibex_csr_rr_arb.sv
// Two-requester round-robin arbiter holding a last-granted pointer.
// Latency: grant is combinational from i_req; pointer updates on the clock edge.
// Backpressure: pointer only moves when i_advance is set, so unaccepted grants do not rotate.
//
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_req         per-port request
//   i_advance     commit the current grant into the pointer
//   o_gnt         one-hot grant (zero when nothing is requested)
module ibex_csr_rr_arb
  import ibex_csr_access_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NumPorts-1:0] i_req,
  input  logic                i_advance,
  output logic [NumPorts-1:0] o_gnt
);

  // 1: port 1 was granted last, so port 0 has priority on contention.
  logic r_last;

  always_comb begin
    o_gnt = '0;
    case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = r_last ? 2'b01 : 2'b10;
      default: o_gnt = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last <= 1'b1;
    end else if (i_advance && (|o_gnt)) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/ibex_csr_access_ctrl.sv
// Two-port sequencer for a bank of shadowed CSRs doing atomic read-modify-write with integrity check.
// Latency: grant in T (combinational), commit at end of T+1, rvalid in T+2; one access per 3 cycles.
// Backpressure: requesters hold req/fields until granted; no grant is issued outside IDLE.
//
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   req_i         per-port request; op_i / addr_i / wdata_i per-port fields
//   gnt_o         one-hot grant pulse (IDLE only)
//   rvalid_o      one-hot response pulse to the granted port
//   rdata_o       value held before the access (0 when out of range)
//   rerr_o        out-of-range or integrity error for this access
//   alert_o       sticky integrity alert, cleared only by reset
module ibex_csr_access_ctrl
  import ibex_csr_access_pkg::*;
#(
  parameter  int               Width      = 32,
  parameter  int               NumRegs    = 8,
  parameter  logic [Width-1:0] ResetValue = '0,
  localparam int               AddrW      = $clog2(NumRegs)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumPorts-1:0]            req_i,
  input  logic [NumPorts-1:0][1:0]       op_i,
  input  logic [NumPorts-1:0][AddrW-1:0] addr_i,
  input  logic [NumPorts-1:0][Width-1:0] wdata_i,
  output logic [NumPorts-1:0]            gnt_o,
  output logic [NumPorts-1:0]            rvalid_o,
  output logic [Width-1:0]               rdata_o,
  output logic                           rerr_o,
  output logic                           alert_o
);

  csr_access_state_e r_state;
  csr_access_state_e w_state_next;

  logic [NumPorts-1:0] w_arb_gnt;
  logic                w_advance;

  // Latched request of the granted port.
  logic             r_port;
  csr_op_e          r_op;
  logic [AddrW-1:0] r_addr;
  logic [Width-1:0] r_wdata;

  logic [Width-1:0] r_regs   [NumRegs];
  logic [Width-1:0] r_shadow [NumRegs];

  logic [Width-1:0] r_rdata;
  logic             r_rerr;
  logic             r_alert;

  logic             w_in_range;
  logic [Width-1:0] w_old;
  logic [Width-1:0] w_shd;
  logic             w_mismatch;
  logic [Width-1:0] w_new;
  logic             w_we;

  ibex_csr_rr_arb u_arb (
    .i_clk     (clk_i),
    .i_rst     (rst_i),
    .i_req     (req_i),
    .i_advance (w_advance),
    .o_gnt     (w_arb_gnt)
  );

  // Sequencer next-state and handshake outputs. Reset masks the pulses so a
  // transaction interrupted by reset never reports a grant or response.
  always_comb begin
    w_state_next = r_state;
    w_advance    = 1'b0;
    gnt_o        = '0;
    rvalid_o     = '0;
    case (r_state)
      IDLE: begin
        if (|req_i) begin
          gnt_o        = w_arb_gnt;
          w_advance    = 1'b1;
          w_state_next = ACCESS;
        end
      end
      ACCESS: w_state_next = RESP;
      RESP: begin
        rvalid_o[r_port] = 1'b1;
        w_state_next     = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (rst_i) begin
      gnt_o     = '0;
      rvalid_o  = '0;
      w_advance = 1'b0;
    end
  end

  // Widened before comparing so a power-of-two bank does not yield a
  // degenerate constant comparison.
  assign w_in_range = (32'(r_addr) < NumRegs);

  // Out-of-range lookups read a consistent (old, ~old) pair so they never
  // look like an integrity fault.
  always_comb begin
    w_old = '0;
    w_shd = '1;
    if (w_in_range) begin
      w_old = r_regs[r_addr];
      w_shd = r_shadow[r_addr];
    end
  end

  assign w_mismatch = w_in_range && (w_old != ~w_shd);

  always_comb begin
    w_new = w_old;
    case (r_op)
      WRITE:   w_new = r_wdata;
      SET:     w_new = w_old | r_wdata;
      CLEAR:   w_new = w_old & ~r_wdata;
      default: w_new = w_old;
    endcase
  end

  // WRITE always commits (it repairs a corrupted entry); SET/CLEAR are
  // suppressed on mismatch because their result would derive from bad data.
  assign w_we = (r_state == ACCESS) && w_in_range &&
                ((r_op == WRITE) ||
                 (((r_op == SET) || (r_op == CLEAR)) && !w_mismatch));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_port  <= 1'b0;
      r_op    <= READ;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rerr  <= 1'b0;
      r_alert <= 1'b0;
      for (int i = 0; i < NumRegs; i++) begin
        r_regs[i]   <= ResetValue;
        r_shadow[i] <= ~ResetValue;
      end
    end else begin
      r_state <= w_state_next;
      if ((r_state == IDLE) && (|req_i)) begin
        r_port  <= w_arb_gnt[1];
        r_op    <= csr_op_e'(op_i[w_arb_gnt[1]]);
        r_addr  <= addr_i[w_arb_gnt[1]];
        r_wdata <= wdata_i[w_arb_gnt[1]];
      end
      if (r_state == ACCESS) begin
        r_rdata <= w_old;
        r_rerr  <= !w_in_range || w_mismatch;
        if (w_mismatch) begin
          r_alert <= 1'b1;
        end
      end
      if (w_we) begin
        r_regs[r_addr]   <= w_new;
        r_shadow[r_addr] <= ~w_new;
      end
    end
  end

  assign rdata_o = r_rdata;
  assign rerr_o  = r_rerr;
  assign alert_o = r_alert;

endmodule
